// File: rtl/rr_req_agent_if.sv
// rr_req_agent_if: bundles the client command ports, the arbiter req/grant
// pair and the shared-resource beat bus of the round-robin requester agent.
//   cmd_valid/cmd_len/cmd_ready : per-channel burst command handshake
//   req/grant                   : request to / one-hot grant from the arbiter
//   beat_valid/ready/ch/last    : beat stream toward the shared resource
//   done/grant_err/starve       : completion pulses and sticky status flags
// Modports: master = the agent, slave = its environment (clients, arbiter,
// resource).
interface rr_req_agent_if #(
  parameter int NCH   = 4,
  parameter int LEN_W = 4
);
  logic [NCH-1:0]       cmd_valid;
  logic [NCH*LEN_W-1:0] cmd_len;
  logic [NCH-1:0]       cmd_ready;
  logic [NCH-1:0]       req;
  logic [NCH-1:0]       grant;
  logic                 beat_valid;
  logic                 beat_ready;
  logic [1:0]           beat_ch;
  logic                 beat_last;
  logic [NCH-1:0]       done;
  logic                 grant_err;
  logic [NCH-1:0]       starve;

  modport master (
    input  cmd_valid, cmd_len, grant, beat_ready,
    output cmd_ready, req, beat_valid, beat_ch, beat_last, done, grant_err, starve
  );

  modport slave (
    output cmd_valid, cmd_len, grant, beat_ready,
    input  cmd_ready, req, beat_valid, beat_ch, beat_last, done, grant_err, starve
  );
endinterface

// File: rtl/rr_req_agent.sv
// rr_req_agent: requester-side agent for a 4-way round-robin arbiter.
// Each channel accepts one burst command (cmd_len+1 beats), raises req, and
// streams its beats to the shared resource while it holds the grant. After
// the last beat it spends one RELEASE cycle with req low, soaking up the
// arbiter's stale grant, before accepting a new command.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - rr_req_agent_if.master (commands, req/grant, beat bus, status)
// Optional feature: define RR_REQ_STARVE_EN to build per-channel wait
// counters that raise a sticky starve flag after TIMEOUT ungranted cycles
// in REQ. Without it starve is tied to zero.
module rr_req_agent #(
  parameter int NCH     = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  rr_req_agent_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } ch_state_e;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("rr_req_agent: TIMEOUT must be at least 2");
  end

  ch_state_e        state_q [NCH];
  ch_state_e        state_d [NCH];
  logic [LEN_W-1:0] rem_q   [NCH];
  logic [LEN_W-1:0] rem_d   [NCH];
  logic [NCH-1:0]   done_q, done_d;
  logic             grant_err_q, grant_err_d;
  // Holds the command ports closed through reset and for the first cycle
  // after it, so cmd_ready only rises once reset has been released.
  logic             ready_en_q, ready_en_d;

  logic             grant_onehot;
  logic [NCH-1:0]   accept;    // command taken this cycle
  logic [NCH-1:0]   issue;     // channel owns the beat bus this cycle
  logic [NCH-1:0]   cmd_ready_c, req_c;
  logic             beat_valid_c, beat_last_c;
  logic [1:0]       beat_ch_c;

  // A beat only goes out under a clean one-hot grant; a multi-hot grant is a
  // protocol error and must not let any channel drive the bus.
  assign grant_onehot = $onehot(bus.grant);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (state_q[i] == ST_IDLE) && bus.cmd_valid[i] && ready_en_q;
      issue[i]  = (state_q[i] == ST_REQ) && grant_onehot && bus.grant[i];
    end
  end

  // Beat bus mux: at most one issue bit can be set, so a priority loop is safe.
  always_comb begin
    beat_valid_c = 1'b0;
    beat_ch_c    = 2'd0;
    beat_last_c  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (issue[i]) begin
        beat_valid_c = 1'b1;
        beat_ch_c    = 2'(i);
        beat_last_c  = (rem_q[i] == '0);
      end
    end
  end

  // Per-channel FSM next state and Moore outputs.
  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    ready_en_d  = 1'b1;
    grant_err_d = grant_err_q | ~$onehot0(bus.grant);
    for (int i = 0; i < NCH; i++) begin
      state_d[i]     = state_q[i];
      rem_d[i]       = rem_q[i];
      done_d[i]      = 1'b0;
      cmd_ready_c[i] = 1'b0;
      req_c[i]       = 1'b0;
      unique case (state_q[i])
        ST_IDLE: begin
          cmd_ready_c[i] = ready_en_q;
          // Granting a channel that never asked is an arbiter fault.
          if (bus.grant[i]) grant_err_d = 1'b1;
          if (accept[i]) begin
            state_d[i] = ST_REQ;
            rem_d[i]   = bus.cmd_len[i*LEN_W +: LEN_W];
          end
        end
        ST_REQ: begin
          req_c[i] = 1'b1;
          if (issue[i] && bus.beat_ready) begin
            if (rem_q[i] == '0) begin
              done_d[i]  = 1'b1;
              state_d[i] = ST_RELEASE;
            end else begin
              rem_d[i] = rem_q[i] - 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          // The arbiter still shows our grant this cycle; it is ignored.
          state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are a handful of control flops, not a
      // memory, so they are reset element by element like any other state.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
      end
      done_q      <= '0;
      grant_err_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
      done_q      <= done_d;
      grant_err_q <= grant_err_d;
      ready_en_q  <= ready_en_d;
    end
  end

`ifdef RR_REQ_STARVE_EN
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  logic [WAIT_W-1:0] wait_q [NCH];
  logic [WAIT_W-1:0] wait_d [NCH];
  logic [NCH-1:0]    starve_q, starve_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wait_d[i]   = wait_q[i];
      starve_d[i] = starve_q[i];
      if (accept[i]) begin
        wait_d[i] = '0;
      end else if ((state_q[i] == ST_REQ) && !bus.grant[i] &&
                   (wait_q[i] != {WAIT_W{1'b1}})) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
      if ((state_q[i] == ST_REQ) && (wait_d[i] >= WAIT_W'(TIMEOUT)))
        starve_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) wait_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) wait_q[i] <= wait_d[i];
      starve_q <= starve_d;
    end
  end

  assign bus.starve = starve_q;
`else
  assign bus.starve = '0;
`endif

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.req        = req_c;
  assign bus.beat_valid = beat_valid_c;
  assign bus.beat_ch    = beat_ch_c;
  assign bus.beat_last  = beat_last_c;
  assign bus.done       = done_q;
  assign bus.grant_err  = grant_err_q;

endmodule

// File: tb/tb_rr_req_agent.sv
// Testbench for rr_req_agent. A behavioural model tracks, per channel, how
// many beats are still owed and whether the post-burst gap is running; a
// registered round-robin arbiter model drives grant from the model's req.
// Every cycle all outputs are compared against the model.
module tb_rr_req_agent;
  localparam int NCH   = 4;
  localparam int LEN_W = 4;
`ifdef RR_REQ_STARVE_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 64;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_req_agent_if #(.NCH(NCH), .LEN_W(LEN_W)) bus ();

  rr_req_agent #(.NCH(NCH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  int       left     [NCH];  // beats still owed by the current burst, 0 = none
  bit       cool     [NCH];  // one-cycle gap after a burst
  bit       done_m   [NCH];
  bit       starve_m [NCH];
  int       wait_m   [NCH];
  bit       err_m;
  bit       up_m;            // command ports open (one cycle after reset)
  logic [NCH-1:0] arb_q;
  int       arb_last;
  bit       force_en;
  logic [NCH-1:0] force_val;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      left[i] = 0; cool[i] = 0; done_m[i] = 0; starve_m[i] = 0; wait_m[i] = 0;
    end
    err_m = 0; up_m = 0; arb_q = '0; arb_last = NCH - 1;
  endtask

  // One clock cycle: drive grant, check outputs, advance the model.
  task automatic step();
    logic [NCH-1:0] g, cv, exp_req, exp_rdy, exp_done, exp_starve;
    logic [LEN_W-1:0] cl [NCH];
    logic br, exp_bv, exp_last, multi, idle_hit;
    logic [1:0] exp_ch;
    int cnt;

    bus.grant = rst ? '0 : (force_en ? force_val : arb_q);
    #1;
    g  = bus.grant;
    br = bus.beat_ready;
    cv = bus.cmd_valid;
    for (int i = 0; i < NCH; i++) cl[i] = bus.cmd_len[i*LEN_W +: LEN_W];

    cnt = $countones(g);
    exp_bv = 0; exp_ch = 0; exp_last = 0;
    for (int i = 0; i < NCH; i++) begin
      exp_req[i]    = (left[i] > 0);
      exp_rdy[i]    = up_m && left[i] == 0 && !cool[i];
      exp_done[i]   = done_m[i];
      exp_starve[i] = starve_m[i];
      if (cnt == 1 && g[i] && left[i] > 0) begin
        exp_bv = 1; exp_ch = 2'(i); exp_last = (left[i] == 1);
      end
    end

    check("req",        bus.req,        exp_req);
    check("cmd_ready",  bus.cmd_ready,  exp_rdy);
    check("beat_valid", bus.beat_valid, exp_bv);
    if (exp_bv || rst) begin
      check("beat_ch",   bus.beat_ch,   exp_ch);
      check("beat_last", bus.beat_last, exp_last);
    end
    check("done",       bus.done,       exp_done);
    check("grant_err",  bus.grant_err,  err_m);
    check("starve",     bus.starve,     exp_starve);

    @(posedge clk);
    if (!rst) begin
      multi    = (cnt > 1);
      idle_hit = 0;
      for (int i = 0; i < NCH; i++)
        if (g[i] && left[i] == 0 && !cool[i]) idle_hit = 1;
      err_m = err_m | multi | idle_hit;
      for (int i = 0; i < NCH; i++) begin
        done_m[i] = 0;
        if (cool[i]) begin
          cool[i] = 0;
        end else if (left[i] > 0) begin
`ifdef RR_REQ_STARVE_EN
          if (!g[i]) wait_m[i]++;
          if (wait_m[i] >= TIMEOUT) starve_m[i] = 1;
`endif
          if (exp_bv && exp_ch == 2'(i) && br) begin
            left[i]--;
            if (left[i] == 0) begin
              cool[i] = 1; done_m[i] = 1;
            end
          end
        end else if (up_m && cv[i]) begin
          left[i]   = int'(cl[i]) + 1;
          wait_m[i] = 0;
        end
      end
      up_m = 1;
      // Arbiter: hold while the owner keeps req, else rotate to the next requester.
      if (!(arb_q != '0 && (arb_q & exp_req) != '0)) begin
        arb_q = '0;
        for (int k = 1; k <= NCH; k++) begin
          int idx;
          idx = (arb_last + k) % NCH;
          if (arb_q == '0 && exp_req[idx]) begin
            arb_q = '0; arb_q[idx] = 1'b1; arb_last = idx;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic issue(input logic [NCH-1:0] valid, input logic [NCH*LEN_W-1:0] len);
    bus.cmd_valid = valid;
    bus.cmd_len   = len;
    step();
    bus.cmd_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.cmd_valid  = '0;
    bus.cmd_len    = '0;
    bus.grant      = '0;
    bus.beat_ready = 1'b1;
    force_en  = 0;
    force_val = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(2);

    // Ch0, 4 beats, resource always ready.
    issue(4'b0001, 16'h0003);
    run(10);

    // Ch1 single beat and ch2 three beats requested together.
    issue(4'b0110, 16'h0200);
    run(12);

    // Ch3, 2 beats, resource stalls the first beat for 3 cycles.
    issue(4'b1000, 16'h1000);
    step();
    bus.beat_ready = 1'b0;
    run(3);
    bus.beat_ready = 1'b1;
    run(6);

    // Multi-hot grant while ch1 is in REQ: no beat, sticky error.
    issue(4'b0010, 16'h00F0);
    run(2);
    force_en = 1; force_val = 4'b0110;
    run(2);
    force_en = 0;
    run(24);
    do_reset();
    run(2);

    // Reset in the middle of a ch0 burst.
    issue(4'b0001, 16'h0003);
    run(2);
    do_reset();
    run(3);

    // Ch2 left ungranted long enough to cross the starvation threshold.
    issue(4'b0100, 16'h0000);
    force_en = 1; force_val = '0;
    run(12);
    force_en = 0;
    run(6);
    do_reset();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      bus.cmd_valid  = NCH'($urandom_range(0, 15)) & NCH'($urandom_range(0, 15));
      bus.cmd_len    = (NCH*LEN_W)'($urandom);
      bus.beat_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.cmd_valid  = '0;
    bus.beat_ready = 1'b1;
    run(80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
